// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the MIPS R2000 pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle between fetch / EX / write-back and the decode stage.
interface decode_stage_if;
  logic [31:0] inst_in;
  logic [31:0] pc4_in;
  logic        valid_in;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_memread;
  logic [4:0]  ex_rt;

  logic        stall_out;
  logic        valid_out;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_sext;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] pc4_out;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        branch;
  logic [1:0]  alu_op;
  logic        illegal_out;

  modport master (
    output inst_in, pc4_in, valid_in, flush, wb_we, wb_addr, wb_data, ex_memread, ex_rt,
    input  stall_out, valid_out, rs_data, rt_data, imm_sext, rs, rt, rd, shamt, funct,
           pc4_out, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch,
           alu_op, illegal_out
  );

  modport slave (
    input  inst_in, pc4_in, valid_in, flush, wb_we, wb_addr, wb_data, ex_memread, ex_rt,
    output stall_out, valid_out, rs_data, rt_data, imm_sext, rs, rt, rd, shamt, funct,
           pc4_out, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch,
           alu_op, illegal_out
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// r0 hardwired to zero, write-through bypass, synchronous clear.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  // Clear on reset; otherwise write any register except r0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Port 1 read: r0 is zero, a same-cycle write to the address is bypassed.
  always_comb begin
    rd1 = '0;
    if (ra1 != 5'd0) begin
      if (we && (wa == ra1)) rd1 = wd;
      else                   rd1 = regs[ra1];
    end
  end

  // Port 2 read: same rules as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 != 5'd0) begin
      if (we && (wa == ra2)) rd2 = wd;
      else                   rd2 = regs[ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS R2000 instruction-decode stage: register read, main control decode,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  logic [5:0]  opcode;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [31:0] rf_rs;
  logic [31:0] rf_rt;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;
  logic        hazard;
  logic        bubble;

  ctrl_t       ctrl_q;

  assign opcode = bus.inst_in[31:26];
  assign f_rs   = bus.inst_in[25:21];
  assign f_rt   = bus.inst_in[20:16];

  regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (f_rs),
    .ra2 (f_rt),
    .rd1 (rf_rs),
    .rd2 (rf_rt),
    .we  (bus.wb_we),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

  // Main control decode from the opcode field.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load-use hazard: a load in EX targets a source of the instruction in decode.
  // Flush wins over the stall; reset also forces the stall low.
  always_comb begin
    hazard        = bus.valid_in && bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == f_rs) || (bus.ex_rt == f_rt));
    bubble        = bus.flush || hazard || !bus.valid_in;
    bus.stall_out = hazard && !bus.flush && !rst;
  end

  // ID/EX register: reset clears, bubble loads zeros, otherwise capture the decode.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      bus.valid_out   <= 1'b0;
      bus.rs_data     <= '0;
      bus.rt_data     <= '0;
      bus.imm_sext    <= '0;
      bus.rs          <= '0;
      bus.rt          <= '0;
      bus.rd          <= '0;
      bus.shamt       <= '0;
      bus.funct       <= '0;
      bus.pc4_out     <= '0;
      ctrl_q          <= '0;
      bus.illegal_out <= 1'b0;
    end else begin
      bus.valid_out   <= 1'b1;
      bus.rs_data     <= rf_rs;
      bus.rt_data     <= rf_rt;
      bus.imm_sext    <= {{16{bus.inst_in[15]}}, bus.inst_in[15:0]};
      bus.rs          <= f_rs;
      bus.rt          <= f_rt;
      bus.rd          <= bus.inst_in[15:11];
      bus.shamt       <= bus.inst_in[10:6];
      bus.funct       <= bus.inst_in[5:0];
      bus.pc4_out     <= bus.pc4_in;
      ctrl_q          <= dec_ctrl;
      bus.illegal_out <= dec_illegal;
    end
  end

  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.branch     = ctrl_q.branch;
  assign bus.alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected ID/EX
// contents into a queue; a monitor pops one entry per clock and compares.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle order: reg_dst alu_src mem_read mem_write mem_to_reg reg_write branch alu_op[1:0]
  localparam logic [8:0] C_R    = 9'b1_0_0_0_0_1_0_10;
  localparam logic [8:0] C_LW   = 9'b0_1_1_0_1_1_0_00;
  localparam logic [8:0] C_SW   = 9'b0_1_0_1_0_0_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_ADDI = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] C_NONE = 9'b0;

  // valid, rs_data, rt_data, imm_sext, rs, rt, rd, shamt, funct, pc4, ctrl, illegal
  typedef logic [164:0] obs_t;

  obs_t exp_q [$];

  function automatic obs_t observe();
    return {bus.valid_out, bus.rs_data, bus.rt_data, bus.imm_sext, bus.rs, bus.rt,
            bus.rd, bus.shamt, bus.funct, bus.pc4_out,
            bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
            bus.reg_write, bus.branch, bus.alu_op, bus.illegal_out};
  endfunction

  // Monitor: one ID/EX snapshot per rising edge, compared against the oldest expectation.
  initial begin
    obs_t got;
    obs_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = observe();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL idex @%0t: got %h want %h", $time, got, want);
        end
      end
    end
  end

  task automatic issue(input logic r, input logic [31:0] inst, input logic [31:0] pc4,
                       input logic v, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic emr, input logic [4:0] ert,
                       input logic exp_stall, input logic exp_v, input logic [8:0] exp_ctrl,
                       input logic exp_ill, input logic [31:0] exp_rsd,
                       input logic [31:0] exp_rtd);
    obs_t want;
    @(posedge clk);
    #2;
    rst            = r;
    bus.inst_in    = inst;
    bus.pc4_in     = pc4;
    bus.valid_in   = v;
    bus.flush      = fl;
    bus.wb_we      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.ex_memread = emr;
    bus.ex_rt      = ert;
    #1;
    vectors++;
    if (bus.stall_out !== exp_stall) begin
      miscompares++;
      $display("FAIL stall @%0t inst %h: got %b want %b", $time, inst, bus.stall_out, exp_stall);
    end
    if (exp_v)
      want = {1'b1, exp_rsd, exp_rtd, {{16{inst[15]}}, inst[15:0]}, inst[25:21], inst[20:16],
              inst[15:11], inst[10:6], inst[5:0], pc4, exp_ctrl, exp_ill};
    else
      want = '0;
    exp_q.push_back(want);
  endtask

  initial begin
    int unsigned guard;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.inst_in = '0; bus.pc4_in = '0; bus.valid_in = 1'b0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_memread = 1'b0; bus.ex_rt = '0;

    // Reset state
    issue(1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, C_NONE, 0, 0, 0);
    issue(1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, C_NONE, 0, 0, 0);
    // r5 = 0xAA, no instruction
    issue(0, 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'hAA, 0, 5'd0, 0, 0, C_NONE, 0, 0, 0);
    // add r3,r5,r0 ; also write r4 = 0x10
    issue(0, 32'h00A01820, 32'h104, 1, 0, 1, 5'd4, 32'h10, 0, 5'd0,
          0, 1, C_R, 0, 32'hAA, 32'h0);
    // sw r7,-4(r2) with same-cycle write of r7 (bypass)
    issue(0, 32'hAC47FFFC, 32'h108, 1, 0, 1, 5'd7, 32'h1234, 0, 5'd0,
          0, 1, C_SW, 0, 32'h0, 32'h1234);
    // addi r9,r4,5 with load to r4 in EX: stall + bubble
    issue(0, 32'h20890005, 32'h10C, 1, 0, 0, 5'd0, 32'h0, 1, 5'd4,
          1, 0, C_NONE, 0, 0, 0);
    // same addi re-decoded after the load leaves EX
    issue(0, 32'h20890005, 32'h10C, 1, 0, 0, 5'd0, 32'h0, 0, 5'd4,
          0, 1, C_ADDI, 0, 32'h10, 32'h0);
    // beq r1,r5 with load to r5 and flush together; write r0 = all ones
    issue(0, 32'h1025FFFE, 32'h110, 1, 1, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd5,
          0, 0, C_NONE, 0, 0, 0);
    // beq hazard on rt only: stall + bubble
    issue(0, 32'h1025FFFE, 32'h110, 1, 0, 0, 5'd0, 32'h0, 1, 5'd5,
          1, 0, C_NONE, 0, 0, 0);
    // beq issues
    issue(0, 32'h1025FFFE, 32'h110, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0,
          0, 1, C_BEQ, 0, 32'h0, 32'hAA);
    // lw r6,8(r0) with load to r0 in EX (never stalls), r0 write again
    issue(0, 32'h8C060008, 32'h114, 1, 0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0,
          0, 1, C_LW, 0, 32'h0, 32'h0);
    // opcode 0x3F valid: illegal, no controls
    issue(0, 32'hFC000000, 32'h118, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0,
          0, 1, C_NONE, 1, 32'h0, 32'h0);
    // same opcode with valid_in=0: plain bubble
    issue(0, 32'hFC000000, 32'h11C, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0,
          0, 0, C_NONE, 0, 0, 0);
    // reset during a load-use hazard: no stall, outputs cleared
    issue(1, 32'h00A01820, 32'h120, 1, 0, 0, 5'd0, 32'h0, 1, 5'd5,
          0, 0, C_NONE, 0, 0, 0);
    // add r3,r5,r0 after reset: registers were cleared
    issue(0, 32'h00A01820, 32'h124, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0,
          0, 1, C_R, 0, 32'h0, 32'h0);
    // idle cycle
    issue(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, C_NONE, 0, 0, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the MIPS R2000 five-stage pipeline, directly downstream of the fetch stage. It consumes the fetched instruction and PC+4, reads operands from the integrated 32×32 register file, and generates main control signals. It also detects load-use hazards and registers everything into the ID/EX pipeline register for the execute stage.

## Interface
- No parameters; widths fixed by the R2000 ISA (32-bit datapath, 5-bit register specifiers).
- clk  in  1  stage clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst_in  in  32  instruction from the fetch stage
- pc4_in  in  32  PC+4 of inst_in
- valid_in  in  1  inst_in holds a real instruction
- flush  in  1  branch taken or exception; squash the instruction in decode
- wb_we  in  1  register-file write enable from write-back
- wb_addr  in  5  write-back destination register
- wb_data  in  32  write-back data
- ex_memread  in  1  instruction currently in EX is a load
- ex_rt  in  5  destination (rt) of the load in EX
- stall_out  out  1  hold PC and fetch-output register this cycle
- valid_out  out  1  ID/EX holds a real instruction
- rs_data, rt_data  out  32  operand values
- imm_sext  out  32  sign-extended inst[15:0]
- rs, rt, rd  out  5  inst[25:21], inst[20:16], inst[15:11]
- shamt  out  5  inst[10:6]
- funct  out  6  inst[5:0]
- pc4_out  out  32  registered pc4_in
- reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch  out  1 each  main control
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- illegal_out  out  1  valid instruction with an unsupported opcode

## Operation
- Register file:
  - Written on the rising edge when wb_we=1 and wb_addr≠0; writes to r0 are ignored.
  - Reads are combinational; r0 always reads 0.
  - Write-through bypass: reading the register being written in the same cycle returns wb_data.
- Decode by opcode = inst_in[31:26]:
  - 0x00 R-type: reg_dst, reg_write, alu_op=10
  - 0x23 lw: alu_src, mem_read, mem_to_reg, reg_write, alu_op=00
  - 0x2B sw: alu_src, mem_write, alu_op=00
  - 0x04 beq: branch, alu_op=01
  - 0x08 addi: alu_src, reg_write, alu_op=00
  - Any other opcode: all controls 0, illegal_out=1.
- Load-use hazard: hazard = valid_in & ex_memread & ex_rt≠0 & (ex_rt==rs | ex_rt==rt).
  - stall_out = hazard & ~flush (combinational).
- ID/EX register update, in priority order:
  - rst: clear all outputs to 0.
  - flush or hazard or ~valid_in: load a bubble (valid_out=0, all controls 0, illegal_out=0; data fields don't-care, driven 0).
  - Otherwise: load the decoded instruction with valid_out=1.
- Fetch must hold inst_in and pc4_in stable while stall_out=1; the stalled instruction is re-decoded the next cycle.

## Timing
- Latency: 1 cycle from inst_in to ID/EX outputs.
- stall_out is combinational from valid_in, inst_in, ex_memread and ex_rt in the same cycle; it has no registered delay.
- Write-back and read of the same register in one cycle: the new value appears in rs_data/rt_data at the next edge.
- Reset:
  - Synchronous clear of all 32 registers and all outputs to 0; stall_out=0 while rst=1.
  - Reset during a stall cancels the stall; there is no residual state.
- Flush and hazard in the same cycle: flush wins; stall_out=0 and a bubble is loaded.
- ex_rt=0 never stalls.

## Structure
- Package mips_pkg:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - ALUOP_* encodings.
  - Packed struct ctrl_t bundling the seven 1-bit controls and alu_op.
- Sub-module regfile: 2 read ports, 1 write port, r0 hardwired, bypass, synchronous reset.
- decode_stage contains the decoder, hazard unit and ID/EX register.

## Test plan
- Reset, then write r5=0x0000_00AA via write-back; decode add r3,r5,r0 (0x00A01820) → next cycle rs_data=0xAA, rt_data=0, reg_dst=1, reg_write=1, alu_op=10, valid_out=1.
- Same cycle: wb_we=1, wb_addr=7, wb_data=0x1234 while decoding sw r7,-4(r2) (0xAC47FFFC) → rt_data=0x1234, imm_sext=0xFFFF_FFFC, mem_write=1.
- ex_memread=1, ex_rt=4, inst_in uses rs=4 → stall_out=1 and a bubble is loaded; next cycle ex_memread=0 → instruction issues with valid_out=1.
- Hazard and flush asserted together → stall_out=0, bubble; write to r0 with 0xFFFF_FFFF → r0 still reads 0.
- Opcode 0x3F with valid_in=1 → illegal_out=1, all controls 0; rst pulse mid-stream → all outputs 0 next cycle.
